// File: rtl/hbridge_pwm_gen.sv
`default_nettype none
// ============================================================================
// hbridge_pwm_gen : full-bridge PWM, two complementary legs with dead time,
//                   shadowed period/duty/dead-time and latched fault shutdown.
// Revision 1.0
// ============================================================================
module hbridge_pwm_gen #(
    parameter int CNT_W      = 16,
    parameter int DT_W       = 8,
    parameter int DEF_PERIOD = 5000,
    parameter int DEF_DUTY   = 1250,
    parameter int DEF_DT     = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             load,
    input  logic [CNT_W-1:0] period_in,
    input  logic [CNT_W-1:0] duty_in,
    input  logic [DT_W-1:0]  dt_in,
    input  logic             fault,
    input  logic             fault_clr,
    output logic [1:0]       hs,
    output logic [1:0]       ls,
    output logic             period_end,
    output logic             fault_latched
);

    localparam logic [CNT_W-1:0] c_def_period = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0] c_def_duty   = CNT_W'(DEF_DUTY);
    localparam logic [DT_W-1:0]  c_def_dt     = DT_W'(DEF_DT);
    localparam logic [CNT_W-1:0] c_min_period = CNT_W'(4);
    localparam logic [DT_W-1:0]  c_dt_one     = DT_W'(1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FAULT = 2'd2} top_state_t;
    typedef enum logic [2:0] {L_OFF = 3'd0, L_LO = 3'd1, L_DTR = 3'd2,
                              L_HI = 3'd3, L_DTF = 3'd4} leg_state_t;

    top_state_t       r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [CNT_W-1:0] r_pend_period, r_pend_duty, r_sh_period, r_sh_duty;
    logic [DT_W-1:0]  r_pend_dt, r_sh_dt;
    logic             r_period_end, r_fault_latched;

    logic [CNT_W-1:0] w_p, w_h, w_d;
    logic [DT_W-1:0]  w_t;
    logic             w_last;
    logic [1:0]       w_ref;
    logic [CNT_W-1:0] w_pend_period, w_pend_duty;
    logic [DT_W-1:0]  w_pend_dt;

    // A load in the same cycle as the shadow copy must reach the shadow directly.
    assign w_pend_period = load ? period_in : r_pend_period;
    assign w_pend_duty   = load ? duty_in   : r_pend_duty;
    assign w_pend_dt     = load ? dt_in     : r_pend_dt;

    assign w_p    = (r_sh_period < c_min_period) ? c_min_period : r_sh_period;
    assign w_h    = w_p >> 1;
    assign w_d    = (r_sh_duty > w_h) ? w_h : r_sh_duty;
    assign w_t    = r_sh_dt;
    assign w_last = (r_cnt >= w_p - 1'b1);

    assign w_ref[0] = (r_cnt < w_d);
    assign w_ref[1] = (r_cnt >= w_h) && (r_cnt < w_h + w_d);

    always_comb begin
        w_state_next = r_state;
        if (fault) begin
            w_state_next = S_FAULT;
        end else begin
            case (r_state)
                S_IDLE:  w_state_next = enable ? S_RUN : S_IDLE;
                S_RUN:   w_state_next = enable ? S_RUN : S_IDLE;
                S_FAULT: w_state_next = fault_clr ? S_IDLE : S_FAULT;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_cnt_next = r_cnt + 1'b1;
        if ((w_state_next != S_RUN) || (r_state != S_RUN) || w_last) begin
            w_cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_pend_period   <= c_def_period;
            r_pend_duty     <= c_def_duty;
            r_pend_dt       <= c_def_dt;
            r_sh_period     <= c_def_period;
            r_sh_duty       <= c_def_duty;
            r_sh_dt         <= c_def_dt;
            r_period_end    <= 1'b0;
            r_fault_latched <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (load) begin
                r_pend_period <= period_in;
                r_pend_duty   <= duty_in;
                r_pend_dt     <= dt_in;
            end
            if ((r_state != S_RUN) || w_last) begin
                r_sh_period <= w_pend_period;
                r_sh_duty   <= w_pend_duty;
                r_sh_dt     <= w_pend_dt;
            end
            // Shadow cannot change before cnt reaches P-1, so the current P is valid here.
            r_period_end    <= (w_state_next == S_RUN) && (w_cnt_next == w_p - 1'b1);
            r_fault_latched <= (w_state_next == S_FAULT);
        end
    end

    assign period_end    = r_period_end;
    assign fault_latched = r_fault_latched;

    for (genvar g = 0; g < 2; g++) begin : g_leg
        leg_state_t      r_leg, w_leg_next;
        logic [DT_W-1:0] r_dtc, w_dtc_next;
        logic            r_hs, r_ls;

        always_comb begin
            w_leg_next = r_leg;
            w_dtc_next = r_dtc;
            if (w_state_next != S_RUN) begin
                w_leg_next = L_OFF;
            end else if (r_state != S_RUN) begin
                w_leg_next = L_LO;
            end else begin
                case (r_leg)
                    L_LO: begin
                        if (w_ref[g]) begin
                            if (w_t == '0) begin
                                w_leg_next = L_HI;
                            end else begin
                                w_leg_next = L_DTR;
                                w_dtc_next = w_t;
                            end
                        end
                    end
                    L_DTR: begin
                        if (!w_ref[g])               w_leg_next = L_LO;
                        else if (r_dtc == c_dt_one)  w_leg_next = L_HI;
                        else                         w_dtc_next = r_dtc - 1'b1;
                    end
                    L_HI: begin
                        if (!w_ref[g]) begin
                            if (w_t == '0) begin
                                w_leg_next = L_LO;
                            end else begin
                                w_leg_next = L_DTF;
                                w_dtc_next = w_t;
                            end
                        end
                    end
                    L_DTF: begin
                        // Low side never came on, so returning high needs no new dead time.
                        if (w_ref[g])                w_leg_next = L_HI;
                        else if (r_dtc == c_dt_one)  w_leg_next = L_LO;
                        else                         w_dtc_next = r_dtc - 1'b1;
                    end
                    default: w_leg_next = L_LO;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_leg <= L_OFF;
                r_dtc <= '0;
                r_hs  <= 1'b0;
                r_ls  <= 1'b0;
            end else begin
                r_leg <= w_leg_next;
                r_dtc <= w_dtc_next;
                r_hs  <= (w_leg_next == L_HI);
                r_ls  <= (w_leg_next == L_LO);
            end
        end

        assign hs[g] = r_hs;
        assign ls[g] = r_ls;
    end

endmodule
`default_nettype wire

// File: tb/tb_hbridge_pwm_gen.sv
`default_nettype none
// ============================================================================
// tb_hbridge_pwm_gen : table of PWM configurations measured per period against
//                      hand-derived edge positions, plus fault/disable/reset runs.
// Revision 1.0
// ============================================================================
module tb_hbridge_pwm_gen;

    logic        clk = 1'b0;
    logic        rst_n, enable, load, fault, fault_clr;
    logic [15:0] period_in, duty_in;
    logic [7:0]  dt_in;
    logic [1:0]  hs, ls;
    logic        period_end, fault_latched;

    always #5 clk = ~clk;

    hbridge_pwm_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .load         (load),
        .period_in    (period_in),
        .duty_in      (duty_in),
        .dt_in        (dt_in),
        .fault        (fault),
        .fault_clr    (fault_clr),
        .hs           (hs),
        .ls           (ls),
        .period_end   (period_end),
        .fault_latched(fault_latched)
    );

    typedef struct {
        int p; int d; int t;
        int hs0_rise; int hs0_ones;
        int ls0_fall; int ls0_zeros;
        int hs1_rise; int hs1_ones;
        int len; int overlap;
    } vec_t;

    vec_t       tbl[6];
    vec_t       sb_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [1:0] prev_hs, prev_ls;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        prev_hs = hs;
        prev_ls = ls;
        @(negedge clk);
    endtask

    task automatic wait_pe();
        bit found = 1'b0;
        for (int i = 0; i < 70000; i++) begin
            cyc();
            if (period_end) begin
                found = 1'b1;
                break;
            end
        end
        check("wait_period_end", int'(found), 1);
    endtask

    // Starts at the period_end sample; the next sample is cnt=0.
    task automatic measure(output vec_t m);
        bit done = 1'b0;
        m.p = 0; m.d = 0; m.t = 0;
        m.hs0_rise = -1; m.hs0_ones = 0; m.ls0_fall = -1; m.ls0_zeros = 0;
        m.hs1_rise = -1; m.hs1_ones = 0; m.len = 0; m.overlap = 0;
        for (int k = 0; k < 70000; k++) begin
            cyc();
            if (hs[0] && !prev_hs[0] && m.hs0_rise < 0) m.hs0_rise = k;
            if (!ls[0] && prev_ls[0] && m.ls0_fall < 0) m.ls0_fall = k;
            if (hs[1] && !prev_hs[1] && m.hs1_rise < 0) m.hs1_rise = k;
            if (hs[0])  m.hs0_ones++;
            if (!ls[0]) m.ls0_zeros++;
            if (hs[1])  m.hs1_ones++;
            if ((hs & ls) != 2'b00) m.overlap++;
            if (period_end) begin
                m.len = k + 1;
                done  = 1'b1;
                break;
            end
        end
        check("measure_timeout", int'(done), 1);
    endtask

    task automatic compare(input vec_t e, input vec_t m, input int idx);
        check($sformatf("v%0d hs0_rise", idx),  m.hs0_rise,  e.hs0_rise);
        check($sformatf("v%0d hs0_ones", idx),  m.hs0_ones,  e.hs0_ones);
        check($sformatf("v%0d ls0_fall", idx),  m.ls0_fall,  e.ls0_fall);
        check($sformatf("v%0d ls0_zeros", idx), m.ls0_zeros, e.ls0_zeros);
        check($sformatf("v%0d hs1_rise", idx),  m.hs1_rise,  e.hs1_rise);
        check($sformatf("v%0d hs1_ones", idx),  m.hs1_ones,  e.hs1_ones);
        check($sformatf("v%0d len", idx),       m.len,       e.len);
        check($sformatf("v%0d overlap", idx),   m.overlap,   e.overlap);
    endtask

    initial begin
        vec_t m, e;
        int   cur, n, first_hs0;
        bit   got;

        //          P     D    T  hs0r hs0n ls0f ls0z hs1r  hs1n len  ovl
        tbl[0] = '{5000, 1250, 12, 13, 1238, 1, 1262, 2513, 1238, 5000, 0};
        tbl[1] = '{100,  30,   5,  6,  25,   1, 35,   56,   25,   100,  0};
        tbl[2] = '{200,  50,   0,  1,  50,   1, 50,   101,  50,   200,  0};
        tbl[3] = '{100,  80,   5,  6,  45,   1, 55,   56,   45,   100,  0};
        tbl[4] = '{100,  3,    5,  -1, 0,    1, 3,    -1,   0,    100,  0};
        tbl[5] = '{2,    1,    0,  1,  1,    1, 1,    3,    1,    4,    0};

        rst_n = 1'b0; enable = 1'b0; load = 1'b0; fault = 1'b0; fault_clr = 1'b0;
        period_in = '0; duty_in = '0; dt_in = '0;
        prev_hs = '0; prev_ls = '0;

        repeat (3) cyc();
        check("reset hs", int'(hs), 0);
        check("reset ls", int'(ls), 0);
        check("reset period_end", int'(period_end), 0);
        check("reset fault_latched", int'(fault_latched), 0);
        rst_n = 1'b1;
        cyc();
        check("idle ls", int'(ls), 0);
        enable = 1'b1;
        cyc();
        check("run entry ls", int'(ls), 3);
        check("run entry hs", int'(hs), 0);

        for (int i = 0; i < 6; i++) begin
            if (i == 0) wait_pe();
            cur = 0;
            got = 1'b0;
            for (int k = 0; k < 70000; k++) begin
                cyc();
                if (k == 10) begin
                    load      = 1'b1;
                    period_in = 16'(tbl[i].p);
                    duty_in   = 16'(tbl[i].d);
                    dt_in     = 8'(tbl[i].t);
                    sb_q.push_back(tbl[i]);
                end else begin
                    load = 1'b0;
                end
                if (period_end) begin
                    cur = k + 1;
                    got = 1'b1;
                    break;
                end
            end
            load = 1'b0;
            check($sformatf("v%0d load_period_len", i), cur, (i == 0) ? 5000 : tbl[i-1].len);
            measure(m);
            check($sformatf("v%0d first_new_len", i), m.len, tbl[i].len);
            measure(m);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                compare(e, m, i);
            end else begin
                check($sformatf("v%0d scoreboard_empty", i), 0, 1);
            end
        end

        // Fault shutdown and release
        load = 1'b1; period_in = 16'd100; duty_in = 16'd30; dt_in = 8'd5;
        cyc();
        load = 1'b0;
        wait_pe();
        wait_pe();
        repeat (11) cyc();
        check("pre-fault hs", int'(hs), 1);
        fault = 1'b1;
        cyc();
        fault = 1'b0;
        check("fault hs", int'(hs), 0);
        check("fault ls", int'(ls), 0);
        check("fault latched", int'(fault_latched), 1);
        cyc();
        check("fault held", int'(fault_latched), 1);
        fault = 1'b1; fault_clr = 1'b1;
        cyc();
        check("fault+clr held", int'(fault_latched), 1);
        fault = 1'b0;
        cyc();
        fault_clr = 1'b0;
        check("clr released", int'(fault_latched), 0);
        check("clr idle ls", int'(ls), 0);
        check("clr idle hs", int'(hs), 0);
        cyc();
        check("rerun ls", int'(ls), 3);
        n = 1;
        got = 1'b0;
        for (int k = 0; k < 70000; k++) begin
            cyc();
            n++;
            if (period_end) begin got = 1'b1; break; end
        end
        check("rerun period_len", got ? n : -1, 100);

        // Disable mid-pulse
        repeat (11) cyc();
        check("pre-disable hs", int'(hs), 1);
        enable = 1'b0;
        cyc();
        check("disable hs", int'(hs), 0);
        check("disable ls", int'(ls), 0);
        cyc();
        check("disable period_end", int'(period_end), 0);

        // Reset mid-run with a pending load
        enable = 1'b1;
        cyc();
        repeat (20) cyc();
        load = 1'b1; period_in = 16'd300; duty_in = 16'd10; dt_in = 8'd0;
        cyc();
        load = 1'b0;
        repeat (5) cyc();
        rst_n = 1'b0;
        cyc();
        check("midrun reset hs", int'(hs), 0);
        check("midrun reset ls", int'(ls), 0);
        check("midrun reset period_end", int'(period_end), 0);
        check("midrun reset fault_latched", int'(fault_latched), 0);
        rst_n = 1'b1;
        cyc();
        check("post-reset run ls", int'(ls), 3);
        n = 1;
        first_hs0 = -1;
        got = 1'b0;
        for (int k = 0; k < 70000; k++) begin
            cyc();
            if (hs[0] && first_hs0 < 0) first_hs0 = n;
            n++;
            if (period_end) begin got = 1'b1; break; end
        end
        check("post-reset period_len", got ? n : -1, 5000);
        check("post-reset hs0_rise", first_hs0, 13);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
